// File: rtl/bus_pkg.sv
// Shared types and constants for the IO/memory bus master slice.
// Provides the one-hot bus-cycle state type, the latched request payload
// and the IO peripheral address window.
package bus_pkg;

   localparam int unsigned BUS_ADDR_W = 16;
   localparam int unsigned BUS_DATA_W = 8;

   // IO peripheral register window
   localparam logic [BUS_ADDR_W-1:0] IO_BASE = 16'hFF00;
   localparam logic [BUS_ADDR_W-1:0] IO_LAST = 16'hFF0F;

   // Bus-cycle phases, one-hot
   typedef enum logic [5:0] {
      IDLE = 6'b000001,
      T1   = 6'b000010,
      T2   = 6'b000100,
      TW   = 6'b001000,
      T3   = 6'b010000,
      T4   = 6'b100000
   } bus_state_e;

   // Request payload captured at acceptance
   typedef struct packed {
      logic [BUS_ADDR_W-1:0] addr;
      logic [BUS_DATA_W-1:0] wdata;
      logic                  write;
      logic                  iom;
   } bus_req_t;

   // True when an address falls inside the IO peripheral window
   function automatic logic in_io_window(input logic [BUS_ADDR_W-1:0] a);
      return (a >= IO_BASE) && (a <= IO_LAST);
   endfunction

endpackage

// File: rtl/io_bus_wait_ctr.sv
// Wait-state counter for the bus master.
// Counts TW cycles from 0; cleared while in T2, advanced in every TW cycle
// (saturating), and flags when the TW cycle currently in progress is at
// least the TW_MIN-th one.
// Ports:
//   CLK     bus clock
//   RESET   asynchronous active-high reset
//   clr     clear the count (master in T2)
//   inc     count one TW cycle (master in TW)
//   done_c  combinational: minimum wait satisfied for the current TW cycle
module io_bus_wait_ctr #(
   parameter int unsigned TW_MIN = 0
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clr,
   input  logic inc,
   output logic done_c
);

   localparam int unsigned CNT_W = 3;

   logic [CNT_W-1:0] cnt;

   // Completed TW cycles of the current transaction
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // cnt + 1 is the ordinal of the TW cycle in progress; one extra bit keeps 7+1 exact
   assign done_c = ({1'b0, cnt} + (CNT_W + 1)'(1)) >= (CNT_W + 1)'(TW_MIN);

endmodule

// File: rtl/io_bus_master.sv
// Upstream bus-cycle generator for the IO/memory bus.
// Turns a single-beat valid/ready request into a T1-T2-[Tw]-T3-T4 bus cycle
// and returns read data with a one-cycle response pulse in T4.
// Ports:
//   CLK, RESET          bus clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (accept on posedge when both high)
//   req_write, req_iom  direction and IO/memory select of the request
//   req_addr, req_wdata target address and write data
//   rsp_valid           one-cycle pulse in T4 of every transaction
//   rsp_rdata           read data captured leaving T3 (held on writes)
//   READY               slave ready, sampled in T2 and TW only
//   ALE                 address latch enable, high in T1
//   IOM                 IO/memory select of the current cycle
//   RD, WR              active-low strobes, low in T2/TW/T3
//   Address             bus address, held from T1 until the next cycle
//   Data                bidirectional data bus, driven only on writes T2..T4
module io_bus_master
   import bus_pkg::*;
#(
   parameter int unsigned TW_MIN = 0,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_iom,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   input  logic              READY,
   output logic              ALE,
   output logic              IOM,
   output logic              RD,
   output logic              WR,
   output logic [ADDR_W-1:0] Address,
   inout  wire  [DATA_W-1:0] Data
);

   bus_state_e state;
   bus_state_e state_nxt_c;
   bus_req_t   req_q;
   logic       data_oe;
   logic       accept_c;
   logic       wait_done_c;
   logic       strobe_c;
   logic       drive_c;

   assign accept_c = req_valid && req_ready;

   // Minimum wait-state tracking
   io_bus_wait_ctr #(
      .TW_MIN (TW_MIN)
   ) u_wait_ctr (
      .CLK    (CLK),
      .RESET  (RESET),
      .clr    (state == T2),
      .inc    (state == TW),
      .done_c (wait_done_c)
   );

   // Next bus phase
   always_comb begin
      state_nxt_c = IDLE;
      case (state)
         IDLE:    state_nxt_c = accept_c ? T1 : IDLE;
         T1:      state_nxt_c = T2;
         T2:      state_nxt_c = ((TW_MIN != 0) || !READY) ? TW : T3;
         TW:      state_nxt_c = (wait_done_c && READY) ? T3 : TW;
         T3:      state_nxt_c = T4;
         T4:      state_nxt_c = accept_c ? T1 : IDLE;
         default: state_nxt_c = IDLE;
      endcase
   end

   // Strobe and data-drive windows of the phase being entered
   assign strobe_c = (state_nxt_c == T2) || (state_nxt_c == TW) || (state_nxt_c == T3);
   assign drive_c  = strobe_c || (state_nxt_c == T4);

   // State register and outputs decoded from the next phase
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         req_q     <= '0;
         req_ready <= 1'b0;
         ALE       <= 1'b0;
         RD        <= 1'b1;
         WR        <= 1'b1;
         data_oe   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= state_nxt_c;
         if (accept_c) begin
            req_q <= '{addr:  BUS_ADDR_W'(req_addr),
                       wdata: BUS_DATA_W'(req_wdata),
                       write: req_write,
                       iom:   req_iom};
         end
         // req_q is already valid whenever a strobe phase is entered (from T1 onward)
         req_ready <= (state_nxt_c == IDLE) || (state_nxt_c == T4);
         ALE       <= (state_nxt_c == T1);
         RD        <= !(strobe_c && !req_q.write);
         WR        <= !(strobe_c && req_q.write);
         data_oe   <= drive_c && req_q.write;
         rsp_valid <= (state_nxt_c == T4);
         // Slave drives Data during T3 of a read
         if ((state == T3) && !req_q.write) begin
            rsp_rdata <= Data;
         end
      end
   end

   // Address and IOM come straight from the request latch, so they hold in IDLE
   assign Address = ADDR_W'(req_q.addr);
   assign IOM     = req_q.iom;
   assign Data    = data_oe ? DATA_W'(req_q.wdata) : {DATA_W{1'bz}};

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Upstream bus-cycle generator for the IO/memory bus; drives ALE, IOM, RD, WR, Address and Data into the IO peripheral (FF00–FF0F window) and memory slaves.
- Converts a single-beat valid/ready request from the core into a T1–T4 bus cycle, with optional Tw wait states, and returns read data with a one-cycle response pulse.
- Bus timing matches the slave FSM, which advances T1→T2→T3→T4 on the master's ALE/RD/WR.

Parameters:
- TW_MIN, 0, minimum wait states inserted after T2 on every cycle (0–7).
- ADDR_W, 16, address width.
- DATA_W, 8, data width.

Ports:
- CLK  in  1  bus clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_iom  in  1  1 = IO cycle, 0 = memory cycle.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse when a transaction completes.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads.
- READY  in  1  slave ready; low inserts Tw states.
- ALE  out  1  address latch enable; high for T1 only.
- IOM  out  1  IO/memory select for the current cycle.
- RD  out  1  active-low read strobe.
- WR  out  1  active-low write strobe.
- Address  out  ADDR_W  bus address.
- Data  inout  DATA_W  bidirectional data bus.

Behaviour:
- Reset (async, immediate) values:
  - State = IDLE; ALE = 0, IOM = 0, RD = 1, WR = 1, Address = 0.
  - Data = high-Z; rsp_valid = 0, rsp_rdata = 0, req_ready = 0.
  - Internal request latches cleared.
- States (one-hot): IDLE, T1, T2, TW, T3, T4.
- req_ready = 1 in IDLE or T4, and RESET low. A request is accepted on a posedge with req_valid && req_ready; addr, wdata, write and iom are latched at that edge.
- Transitions:
  - IDLE → T1 on accept; otherwise stay in IDLE.
  - T1 → T2 always.
  - T2 → TW if TW_MIN > 0 or READY == 0; otherwise T2 → T3.
  - TW → T3 once the wait counter reaches TW_MIN and READY == 1; otherwise stay in TW. Counter counts TW cycles from 0.
  - T3 → T4 always.
  - T4 → T1 if a new request is accepted in T4 (back-to-back); otherwise T4 → IDLE.
- Outputs are registered and decoded from the next state, so they change coincident with state entry.
- Address and IOM are driven from the latched request from T1 through T4, held stable. In IDLE they keep their last values.
- ALE = 1 in T1 only.
- RD = 0 in T2, TW and T3 on reads; WR = 0 in T2, TW and T3 on writes. The other strobe stays at 1.
- Data is driven with the latched wdata in T2, TW, T3 and T4 on writes; it is high-Z at all other times and on reads. The master never drives Data while RD is low.
- Read capture: rsp_rdata is loaded from Data on the posedge leaving T3. This is the cycle where the slave drives Data (slave in T3_R).
- rsp_valid = 1 for exactly the T4 cycle of every transaction, read or write. On writes rsp_rdata holds its previous value.
- Latency with TW_MIN = 0 and READY = 1:
  - Accept edge at cycle 0; T1 = cycle 1, T2 = cycle 2, T3 = cycle 3, T4 = cycle 4 (rsp_valid).
  - Each Tw adds 1 cycle.
  - Back-to-back throughput is 1 transaction per 4 cycles.
- READY is sampled only in T2 and TW and ignored elsewhere.
- Reset asserted mid-transaction: the bus returns to idle values asynchronously, the transaction is dropped and no rsp_valid is produced. The slave re-synchronises through its own reset.
- req_valid with req_ready = 0: no effect. The core holds the request; it is not required to be stable until acceptance.

Decomposition:
- Shared package bus_pkg:
  - bus_state_e, the one-hot enum IDLE/T1/T2/TW/T3/T4.
  - bus_req_t, a struct with addr, wdata, write, iom.
  - Constants IO_BASE = 16'hFF00 and IO_LAST = 16'hFF0F.
- One sub-module is natural: io_bus_wait_ctr, a 3-bit counter with clear in T2, increment in TW, and a done flag at TW_MIN.

Test Plan:
- Read, idle wait: slave preloaded io[FF03] = 8'h5A; request read iom=1 addr=FF03, READY=1 → ALE high cycle 1, RD low cycles 2–3, rsp_valid cycle 4 with rsp_rdata = 8'h5A, Data high-Z from master throughout.
- Write then read-back: write FF05 = 8'hA7, then read FF05 → WR low cycles 2–3 with Data = 8'hA7 held through T4; second rsp_rdata = 8'hA7.
- READY wait states: READY held low for 2 cycles from T2 → two TW cycles, RD held low for them, rsp_valid at cycle 6, Address constant FF03 cycles 1–6.
- Back-to-back: req_valid held high with reads FF00 then FF01 → second ALE in cycle 5 directly after T4, with no IDLE cycle between.
- TW_MIN=2, READY=1: one read → exactly 2 TW cycles, rsp_valid at cycle 6.
- Async reset during T2 of a write: RD/WR return to 1, ALE 0 and Data high-Z in the same cycle without waiting for a CLK edge; rsp_valid never pulses; after release, req_ready = 1 and the next read of FF00 completes normally.
